// File: rtl/mips_defs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_defs : opcode/funct constants, datapath select encodings, FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JUMP = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    localparam logic [1:0] WR_RT    = 2'b00;
    localparam logic [1:0] WR_RD    = 2'b01;
    localparam logic [1:0] WR_RA    = 2'b10;

    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MEM   = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    localparam logic [1:0] B_RT     = 2'b00;
    localparam logic [1:0] B_IMM    = 2'b01;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b100;
    localparam logic [2:0] ALU_DEF  = 3'b101;

    typedef logic [2:0] state_t;
    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXE    = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;

    typedef struct packed {
        logic add;
        logic sub;
        logic ori;
        logic lw;
        logic sw;
        logic lui;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic nop;
    } instr_class_t;

endpackage
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_decode : Opcode/Funct to one-hot instruction class plus unknown flag
// Rev 1.0
// ---------------------------------------------------------------------------
module mc_decode
    import mips_defs::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic         unknown
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  cls.add = 1'b1;
                    FN_SUB:  cls.sub = 1'b1;
                    FN_JR:   cls.jr  = 1'b1;
                    FN_NOP:  cls.nop = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_J:    cls.j   = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: ;
        endcase
    end

    assign unknown = ~|cls;

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mc_control : multi-cycle FETCH/DECODE/EXE/MEM/WB sequencer for MIPS-lite
// Rev 1.0
// ---------------------------------------------------------------------------
module mc_control
    import mips_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        im_ready,
    input  logic        dm_ready,
    output logic        im_req,
    output logic        dm_req,
    output logic        IRWr,
    output logic        PCWr,
    output logic [1:0]  NPCop,
    output logic [1:0]  WRsel,
    output logic [1:0]  WDsel,
    output logic        EXTop,
    output logic [1:0]  Bsel,
    output logic [2:0]  ALUop,
    output logic        RFWr,
    output logic        DMWr,
    output logic [31:0] instr_cnt
);

    state_t       state;
    state_t       next_state;
    instr_class_t cls;
    logic         unknown;
    logic [2:0]   life_alu;
    logic [1:0]   life_bsel;
    logic         life_ext;

    mc_decode u_decode (
        .opcode  (Opcode),
        .funct   (Funct),
        .cls     (cls),
        .unknown (unknown)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_FETCH;
            instr_cnt <= 32'd0;
        end else begin
            state <= next_state;
            if (PCWr) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
        end
    end

    // ALU/B/EXT selects are a pure function of the instruction, held from EXE to WB
    always_comb begin
        life_alu  = ALU_DEF;
        life_bsel = B_RT;
        if (cls.add || cls.lw || cls.sw) life_alu = ALU_ADD;
        if (cls.sub || cls.beq)          life_alu = ALU_SUB;
        if (cls.ori)                     life_alu = ALU_OR;
        if (cls.lui)                     life_alu = ALU_LUI;
        if (cls.ori || cls.lw || cls.sw || cls.lui) life_bsel = B_IMM;
        life_ext = cls.lw | cls.sw;
    end

    always_comb begin
        next_state = state;
        im_req     = 1'b0;
        dm_req     = 1'b0;
        IRWr       = 1'b0;
        PCWr       = 1'b0;
        NPCop      = NPC_PC4;
        WRsel      = WR_RT;
        WDsel      = WD_ALU;
        EXTop      = 1'b0;
        Bsel       = B_RT;
        ALUop      = ALU_DEF;
        RFWr       = 1'b0;
        DMWr       = 1'b0;

        if (state == ST_EXE || state == ST_MEM || state == ST_WB) begin
            ALUop = life_alu;
            Bsel  = life_bsel;
            EXTop = life_ext;
        end

        case (state)
            ST_FETCH: begin
                im_req = 1'b1;
                if (im_ready) begin
                    IRWr       = 1'b1;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                next_state = ST_FETCH;
                if (cls.j) begin
                    PCWr  = 1'b1;
                    NPCop = NPC_JUMP;
                end else if (cls.jal) begin
                    PCWr  = 1'b1;
                    NPCop = NPC_JUMP;
                    RFWr  = 1'b1;
                    WRsel = WR_RA;
                    WDsel = WD_PC4;
                end else if (cls.jr) begin
                    PCWr  = 1'b1;
                    NPCop = NPC_JR;
                end else if (cls.nop || unknown) begin
                    PCWr  = 1'b1;
                end else begin
                    next_state = ST_EXE;
                end
            end
            ST_EXE: begin
                if (cls.beq) begin
                    PCWr       = 1'b1;
                    NPCop      = Zero ? NPC_BR : NPC_PC4;
                    next_state = ST_FETCH;
                end else if (cls.lw || cls.sw) begin
                    next_state = ST_MEM;
                end else begin
                    next_state = ST_WB;
                end
            end
            ST_MEM: begin
                dm_req = 1'b1;
                DMWr   = cls.sw;
                if (dm_ready) begin
                    if (cls.sw) begin
                        PCWr       = 1'b1;
                        next_state = ST_FETCH;
                    end else begin
                        next_state = ST_WB;
                    end
                end
            end
            ST_WB: begin
                RFWr       = 1'b1;
                PCWr       = 1'b1;
                WRsel      = (cls.add || cls.sub) ? WR_RD : WR_RT;
                WDsel      = cls.lw ? WD_MEM : WD_ALU;
                next_state = ST_FETCH;
            end
            default: next_state = ST_FETCH;
        endcase

        // Reset is asynchronous, so every request/strobe is forced low combinationally too
        if (reset) begin
            im_req = 1'b0;
            dm_req = 1'b0;
            IRWr   = 1'b0;
            PCWr   = 1'b0;
            RFWr   = 1'b0;
            DMWr   = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mc_control : directed plus randomized instruction streams against a
// per-instruction cycle schedule built from the control rules
// ---------------------------------------------------------------------------
module tb_mc_control;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  Opcode = 6'd0;
    logic [5:0]  Funct = 6'd0;
    logic        Zero = 1'b0;
    logic        im_ready = 1'b0;
    logic        dm_ready = 1'b0;
    logic        im_req, dm_req, IRWr, PCWr, EXTop, RFWr, DMWr;
    logic [1:0]  NPCop, WRsel, WDsel, Bsel;
    logic [2:0]  ALUop;
    logic [31:0] instr_cnt;

    mc_control dut (
        .clk       (clk),
        .reset     (reset),
        .Opcode    (Opcode),
        .Funct     (Funct),
        .Zero      (Zero),
        .im_ready  (im_ready),
        .dm_ready  (dm_ready),
        .im_req    (im_req),
        .dm_req    (dm_req),
        .IRWr      (IRWr),
        .PCWr      (PCWr),
        .NPCop     (NPCop),
        .WRsel     (WRsel),
        .WDsel     (WDsel),
        .EXTop     (EXTop),
        .Bsel      (Bsel),
        .ALUop     (ALUop),
        .RFWr      (RFWr),
        .DMWr      (DMWr),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       im_req;
        logic       dm_req;
        logic       irwr;
        logic       pcwr;
        logic [1:0] npcop;
        logic [1:0] wrsel;
        logic [1:0] wdsel;
        logic       extop;
        logic [1:0] bsel;
        logic [2:0] aluop;
        logic       rfwr;
        logic       dmwr;
    } outs_t;

    typedef struct {
        bit         fetch;
        logic       imr;
        logic       dmr;
        logic       zero;
        logic [7:0] ph;
        outs_t      exp;
    } cyc_t;

    typedef enum int {K_ADD, K_SUB, K_ORI, K_LW, K_SW, K_LUI, K_BEQ,
                      K_J, K_JAL, K_JR, K_NOP, K_UNK, K_UNKR} kind_t;

    outs_t obs;
    assign obs = {im_req, dm_req, IRWr, PCWr, NPCop, WRsel, WDsel,
                  EXTop, Bsel, ALUop, RFWr, DMWr};

    int          checks = 0;
    int          passes = 0;
    int          instr_no = 0;
    logic [31:0] model_cnt = 32'd0;
    cyc_t        sched[$];

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, o, e);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic cyc_t mk(bit f, logic imr, logic dmr, logic z, logic [7:0] ph, outs_t e);
        cyc_t c;
        c.fetch = f; c.imr = imr; c.dmr = dmr; c.zero = z; c.ph = ph; c.exp = e;
        return c;
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction, derived from its class
    task automatic build(input kind_t k, input int imw, input int dmw, input logic z);
        outs_t d, life, e;
        bit is_mem;
        d = '0;
        d.aluop = 3'b101;
        life = d;
        case (k)
            K_ADD: life.aluop = 3'b000;
            K_SUB: life.aluop = 3'b001;
            K_ORI: begin life.aluop = 3'b011; life.bsel = 2'b01; end
            K_LW, K_SW: begin life.aluop = 3'b000; life.bsel = 2'b01; life.extop = 1'b1; end
            K_LUI: begin life.aluop = 3'b100; life.bsel = 2'b01; end
            K_BEQ: life.aluop = 3'b001;
            default: ;
        endcase
        sched.delete();
        for (int i = 0; i < imw; i++) begin
            e = d; e.im_req = 1'b1;
            sched.push_back(mk(1'b1, 1'b0, rbit(), rbit(), "F", e));
        end
        e = d; e.im_req = 1'b1; e.irwr = 1'b1;
        sched.push_back(mk(1'b1, 1'b1, rbit(), rbit(), "F", e));

        e = d;
        if (k inside {K_J, K_JAL, K_JR, K_NOP, K_UNK, K_UNKR}) begin
            e.pcwr = 1'b1;
            if (k == K_J || k == K_JAL) e.npcop = 2'b10;
            if (k == K_JR) e.npcop = 2'b11;
            if (k == K_JAL) begin e.rfwr = 1'b1; e.wrsel = 2'b10; e.wdsel = 2'b10; end
            sched.push_back(mk(1'b0, rbit(), rbit(), rbit(), "D", e));
            return;
        end
        sched.push_back(mk(1'b0, rbit(), rbit(), rbit(), "D", e));

        e = life;
        if (k == K_BEQ) begin
            e.pcwr = 1'b1;
            e.npcop = z ? 2'b01 : 2'b00;
            sched.push_back(mk(1'b0, rbit(), rbit(), z, "E", e));
            return;
        end
        sched.push_back(mk(1'b0, rbit(), rbit(), rbit(), "E", e));

        is_mem = (k == K_LW || k == K_SW);
        if (is_mem) begin
            for (int i = 0; i < dmw; i++) begin
                e = life; e.dm_req = 1'b1; e.dmwr = (k == K_SW);
                sched.push_back(mk(1'b0, rbit(), 1'b0, rbit(), "M", e));
            end
            e = life; e.dm_req = 1'b1; e.dmwr = (k == K_SW); e.pcwr = (k == K_SW);
            sched.push_back(mk(1'b0, rbit(), 1'b1, rbit(), "M", e));
            if (k == K_SW) return;
        end

        e = life; e.rfwr = 1'b1; e.pcwr = 1'b1;
        e.wrsel = (k == K_ADD || k == K_SUB) ? 2'b01 : 2'b00;
        e.wdsel = (k == K_LW) ? 2'b01 : 2'b00;
        sched.push_back(mk(1'b0, rbit(), rbit(), rbit(), "W", e));
    endtask

    // Starts and ends at posedge+1; stop>0 runs only that many cycles (no retirement)
    task automatic run_instr(input kind_t k, input int imw, input int dmw, input logic z, input int stop);
        logic [5:0] op, fn;
        int n;
        fn = 6'($urandom);
        case (k)
            K_ADD:  begin op = 6'h00; fn = 6'h20; end
            K_SUB:  begin op = 6'h00; fn = 6'h22; end
            K_JR:   begin op = 6'h00; fn = 6'h08; end
            K_NOP:  begin op = 6'h00; fn = 6'h00; end
            K_UNKR: begin op = 6'h00; fn = 6'h2A; end
            K_ORI:  op = 6'h0D;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2B;
            K_LUI:  op = 6'h0F;
            K_BEQ:  op = 6'h04;
            K_J:    op = 6'h02;
            K_JAL:  op = 6'h03;
            default: op = 6'h3F;
        endcase
        build(k, imw, dmw, z);
        n = (stop > 0 && stop < sched.size()) ? stop : sched.size();
        for (int i = 0; i < n; i++) begin
            Opcode   = sched[i].fetch ? 6'($urandom) : op;
            Funct    = sched[i].fetch ? 6'($urandom) : fn;
            im_ready = sched[i].imr;
            dm_ready = sched[i].dmr;
            Zero     = sched[i].zero;
            @(negedge clk);
            chk($sformatf("outs instr%0d kind%0d cyc%0d %c", instr_no, k, i, sched[i].ph),
                32'(obs), 32'(sched[i].exp));
            @(posedge clk);
            #1;
        end
        if (stop == 0) begin
            model_cnt = model_cnt + 32'd1;
            chk($sformatf("instr_cnt instr%0d", instr_no), instr_cnt, model_cnt);
        end
        instr_no++;
    endtask

    initial begin
        outs_t rst_exp;
        rst_exp = '0;
        rst_exp.aluop = 3'b101;
        im_ready = 1'b1;
        dm_ready = 1'b1;
        #2;
        chk("reset_outs", 32'(obs), 32'(rst_exp));
        chk("reset_cnt", instr_cnt, 32'd0);
        @(negedge clk);
        im_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("first_im_req", 32'(im_req), 32'd1);
        @(posedge clk);
        #1;

        run_instr(K_ADD, 0, 0, 1'b0, 0);
        run_instr(K_LW,  0, 3, 1'b0, 0);
        run_instr(K_BEQ, 0, 0, 1'b1, 0);
        run_instr(K_BEQ, 0, 0, 1'b0, 0);
        run_instr(K_JAL, 0, 0, 1'b0, 0);
        run_instr(K_SW,  2, 0, 1'b0, 0);
        run_instr(K_J,   1, 0, 1'b0, 0);
        run_instr(K_JR,  0, 0, 1'b0, 0);
        run_instr(K_UNKR, 0, 0, 1'b0, 0);

        // sw stalled in MEM, then reset asserted mid-cycle
        run_instr(K_SW, 0, 6, 1'b0, 5);
        dm_ready = 1'b0;
        im_ready = 1'b1;
        #1;
        chk("stall_dmwr", 32'(DMWr), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_dmwr", 32'(DMWr), 32'd0);
        chk("rst_dm_req", 32'(dm_req), 32'd0);
        chk("rst_outs", 32'(obs), 32'(rst_exp));
        chk("rst_cnt", instr_cnt, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_outs", 32'(obs), 32'(rst_exp));
        @(negedge clk);
        im_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("release_im_req", 32'(im_req), 32'd1);
        @(posedge clk);
        #1;
        model_cnt = 32'd0;
        run_instr(K_UNK, 0, 0, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            run_instr(kind_t'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), rbit(), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
